// File: rtl/periph_bus_master_pkg.sv
// Shared definitions for the peripheral bus master slice.
//   - request size encodings (SIZE_BYTE/HALF/WORD, 2'd3 behaves as word)
//   - FSM state enum (IDLE, RD, RWAIT, WR, RESP)
//   - PERIPH_TAG_MSB/LSB: address field that selects a peripheral (addr[31:22])
//   - is_misaligned(): alignment rule for a size/low-address pair
package periph_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int PERIPH_TAG_MSB = 31;
  localparam int PERIPH_TAG_LSB = 22;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Bytes are always aligned; halves need addr[0]=0; words (and size 3) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_HALF) bad = addr_lo[0];
    else if (size[1])      bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Signal bundle between the core load/store stage, the bus master and the
// peripheral decode.
//   req_*  : core request   (valid/ready)
//   resp_* : core response  (valid/ready)
//   bus_*  : word-wide peripheral register bus (addr, wr/re strobes, data)
// Handshake rule for both req and resp: a transfer happens on a rising clock
// edge where valid and ready are both high; valid, once raised by the source,
// is held with stable payload until that edge.
// Modports:
//   master : the bus master block (accepts requests, drives responses and bus)
//   slave  : the environment (core side + peripheral side)
interface periph_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wr;
  logic              bus_re;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output bus_addr, bus_wr, bus_re, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  bus_addr, bus_wr, bus_re, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/periph_bus_master_lane_align.sv
// periph_lane_align: combinational lane handling for the bus master.
//   size, is_unsigned, addr_lo : request attributes
//   wdata      : right-justified store data
//   rdata      : word read from the bus
//   load_data  : selected byte/half lane, zero- or sign-extended
//   store_data : word to write on the bus
//   misaligned : request violates alignment
// Build option SUBWORD_RMW_EN: when defined, sub-word stores merge into rdata
// (the previously read register); otherwise the data is replicated to all lanes.
module periph_lane_align
  import periph_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic        misaligned
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    b_lane = rdata[{addr_lo, 3'b000} +: 8];
    h_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    if (size == SIZE_BYTE)
      load_data = is_unsigned ? {24'h0, b_lane} : {{24{b_lane[7]}}, b_lane};
    else if (size == SIZE_HALF)
      load_data = is_unsigned ? {16'h0, h_lane} : {{16{h_lane[15]}}, h_lane};
  end

  always_comb begin
    store_data = wdata;
`ifdef SUBWORD_RMW_EN
    if (size == SIZE_BYTE) begin
      store_data = rdata;
      store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SIZE_HALF) begin
      store_data = rdata;
      store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
    end
`else
    if (size == SIZE_BYTE)      store_data = {4{wdata[7:0]}};
    else if (size == SIZE_HALF) store_data = {2{wdata[15:0]}};
`endif
  end

  assign misaligned = is_misaligned(size, addr_lo);

endmodule

// File: rtl/periph_bus_master.sv
// periph_bus_master: converts one core load/store at a time into word-wide
// peripheral register bus cycles.
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   bus        : periph_bus_master_if.master (req_*, resp_*, bus_*)
//   dbg_state  : current FSM state
// Parameters: RD_LATENCY (0..3 cycles from bus_re to valid bus_rdata), ADDR_W.
// Build option SUBWORD_RMW_EN: byte/half stores read the register first and
// write back the merged word; without it they write replicated lanes directly.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  periph_bus_master_if.master bus,
  output state_t              dbg_state
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t      state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  lat_addr_lo;  // upper address bits live on in bus_addr
  logic [31:0] lat_wdata;
  logic [1:0]  lat_cnt;

  logic [1:0]  al_size;
  logic        al_uns;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic [31:0] al_store;
  logic        al_misaligned;

  logic        accept;
  logic        cap_now;
  logic        rmw_sub;

  // The aligner sees the live request while idle (decisions at accept time)
  // and the latched copy afterwards (capture and merge).
  always_comb begin
    if (state == IDLE) begin
      al_size    = bus.req_size;
      al_uns     = bus.req_unsigned;
      al_addr_lo = bus.req_addr[1:0];
      al_wdata   = bus.req_wdata;
    end else begin
      al_size    = lat_size;
      al_uns     = lat_uns;
      al_addr_lo = lat_addr_lo;
      al_wdata   = lat_wdata;
    end
  end

  assign accept  = bus.req_valid && bus.req_ready;
  // Read data is sampled RD_LATENCY cycles after the RD cycle (in RD itself when 0).
  assign cap_now = ((state == RD) && (LAT == 2'd0)) || ((state == RWAIT) && (lat_cnt == LAT));

`ifdef SUBWORD_RMW_EN
  assign rmw_sub = bus.req_we && !bus.req_size[1];
`else
  assign rmw_sub = 1'b0;
`endif

  periph_lane_align u_align (
    .size        (al_size),
    .is_unsigned (al_uns),
    .addr_lo     (al_addr_lo),
    .wdata       (al_wdata),
    .rdata       (bus.bus_rdata),
    .load_data   (al_load),
    .store_data  (al_store),
    .misaligned  (al_misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      lat_we         <= 1'b0;
      lat_size       <= 2'd0;
      lat_uns        <= 1'b0;
      lat_addr_lo    <= 2'd0;
      lat_wdata      <= 32'h0;
      lat_cnt        <= 2'd0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.bus_addr   <= '0;
      bus.bus_wr     <= 1'b0;
      bus.bus_re     <= 1'b0;
      bus.bus_wdata  <= 32'h0;
    end else begin
      // Strobes last exactly one cycle.
      bus.bus_re <= 1'b0;
      bus.bus_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we        <= bus.req_we;
            lat_size      <= bus.req_size;
            lat_uns       <= bus.req_unsigned;
            lat_addr_lo   <= bus.req_addr[1:0];
            lat_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (al_misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else begin
              bus.bus_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (!bus.req_we || rmw_sub) begin
                state      <= RD;
                bus.bus_re <= 1'b1;
              end else begin
                state         <= WR;
                bus.bus_wr    <= 1'b1;
                bus.bus_wdata <= al_store;
              end
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        RD, RWAIT: begin
          if (cap_now) begin
            if (lat_we) begin
              // Read half of a read-modify-write store: write the merged word.
              state         <= WR;
              bus.bus_wr    <= 1'b1;
              bus.bus_wdata <= al_store;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= al_load;
            end
          end else if (state == RD) begin
            state   <= RWAIT;
            lat_cnt <= 2'd1;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        WR: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0;
        end

        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_periph_bus_master.sv
module tb_periph_bus_master;
  import periph_bus_pkg::*;

  localparam int RD_LATENCY = 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] periph;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic        err;
    int          lat;
    int          n_re;
    int          n_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [31:0] periph_reg = 32'h0;
  logic        re_prev    = 1'b0;

  logic [31:0] exp_q[$];
  exp_t        meta_q[$];
  vec_t        vecs[$];

  periph_bus_master_if #(.ADDR_W(32)) bif();

  periph_bus_master #(.RD_LATENCY(RD_LATENCY), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif.master),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * addr[1:0])) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (size == 2'd1) begin
      v = (word >> (16 * addr[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [31:0] old);
    logic [31:0] mask;
    int          sh;
    if (size >= 2'd2) return wdata;
`ifdef SUBWORD_RMW_EN
    sh   = (size == 2'd0) ? 8 * addr[1:0] : 16 * addr[1];
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wdata << sh) & mask);
`else
    sh   = 0;
    mask = 32'h0;
    if (size == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101 | mask | 32'(sh) & 32'h0 | old & 32'h0;
    return (wdata & 32'hFFFF) * 32'h0001_0001;
`endif
  endfunction

  function automatic exp_t model_meta(input vec_t v);
    exp_t e;
    e.err   = model_err(v.size, v.addr);
    e.addr  = v.addr & 32'hFFFF_FFFC;
    e.wdata = model_store(v.size, v.addr, v.wdata, v.periph);
    e.n_re  = 0;
    e.n_wr  = 0;
    if (e.err)     e.lat = 1;
    else if (!v.we) begin e.lat = 2 + RD_LATENCY; e.n_re = 1; end
    else if (v.size < 2'd2) begin
`ifdef SUBWORD_RMW_EN
      e.lat = 3 + RD_LATENCY; e.n_re = 1; e.n_wr = 1;
`else
      e.lat = 2; e.n_wr = 1;
`endif
    end else begin
      e.lat = 2; e.n_wr = 1;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] periph, input logic [31:0] exp_rdata,
                              input logic exp_err, input int hold);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.periph = periph; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.hold = hold;
    return v;
  endfunction

  // ---------------- peripheral responder ----------------
  // Read data appears for one cycle, RD_LATENCY(=1) cycle after the bus_re cycle.
  always @(negedge clk) begin
    bif.bus_rdata = re_prev ? periph_reg : 32'h5A5A_5A5A;
    re_prev = bif.bus_re;
  end

  // ---------------- compare process ----------------
  bit          active    = 1'b0;
  bit          responded = 1'b0;
  exp_t        cur;
  logic [31:0] cur_rdata;
  logic [31:0] first_rdata;
  int          acc_cyc, re_cnt, wr_cnt;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      active = 1'b0;
      check("rst_req_ready",  32'(bif.req_ready),  32'h0);
      check("rst_resp_valid", 32'(bif.resp_valid), 32'h0);
      check("rst_resp_err",   32'(bif.resp_err),   32'h0);
      check("rst_strobes",    {30'h0, bif.bus_re, bif.bus_wr}, 32'h0);
      check("rst_resp_rdata", bif.resp_rdata, 32'h0);
      check("rst_bus_addr",   bif.bus_addr,   32'h0);
      check("rst_bus_wdata",  bif.bus_wdata,  32'h0);
    end else if (active) begin
      check("busy_req_ready", 32'(bif.req_ready), 32'h0);
      check("strobe_excl", 32'(bif.bus_re & bif.bus_wr), 32'h0);
      if (bif.bus_re) begin
        re_cnt++;
        check("re_addr", bif.bus_addr, cur.addr);
      end
      if (bif.bus_wr) begin
        check("reads_before_wr", 32'(re_cnt), 32'(cur.n_re));
        wr_cnt++;
        check("wr_addr",  bif.bus_addr,  cur.addr);
        check("wr_wdata", bif.bus_wdata, cur.wdata);
      end
      if (bif.resp_valid) begin
        if (!responded) begin
          responded   = 1'b1;
          first_rdata = bif.resp_rdata;
          check("latency",    32'(cyc - acc_cyc), 32'(cur.lat));
          check("resp_rdata", bif.resp_rdata, cur_rdata);
          check("resp_err",   32'(bif.resp_err), 32'(cur.err));
          check("n_re",       32'(re_cnt), 32'(cur.n_re));
          check("n_wr",       32'(wr_cnt), 32'(cur.n_wr));
        end else begin
          check("resp_stable", bif.resp_rdata, first_rdata);
        end
        if (cur.n_re + cur.n_wr > 0) check("addr_stable", bif.bus_addr, cur.addr);
        if (bif.resp_ready) active = 1'b0;
      end
    end else begin
      check("idle_quiet", {29'h0, bif.resp_valid, bif.bus_re, bif.bus_wr}, 32'h0);
      if (bif.req_valid && bif.req_ready) begin
        if (meta_q.size() == 0 || exp_q.size() == 0) begin
          check("unexpected_accept", 32'h1, 32'h0);
        end else begin
          cur       = meta_q.pop_front();
          cur_rdata = exp_q.pop_front();
          active    = 1'b1;
          responded = 1'b0;
          acc_cyc   = cyc;
          re_cnt    = 0;
          wr_cnt    = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_model(input vec_t v);
    exp_t e;
    e = model_meta(v);
    meta_q.push_back(e);
    exp_q.push_back((e.err || v.we) ? 32'h0 : model_load(v.size, v.uns, v.addr, v.periph));
  endtask

  task automatic issue(input vec_t v, output bit ok);
    int t;
    periph_reg = v.periph;
    push_model(v);
    @(posedge clk); #1;
    bif.req_we       = v.we;
    bif.req_size     = v.size;
    bif.req_unsigned = v.uns;
    bif.req_addr     = v.addr;
    bif.req_wdata    = v.wdata;
    bif.req_valid    = 1'b1;
    ok = 1'b0;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bif.req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bif.req_valid    = 1'b0;
    bif.req_we       = 1'($urandom_range(1, 0));
    bif.req_size     = 2'($urandom_range(3, 0));
    bif.req_unsigned = 1'($urandom_range(1, 0));
    bif.req_addr     = $urandom;
    bif.req_wdata    = $urandom;
    if (!ok) check("accept_timeout", 32'h1, 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    bit          ok;
    bit          seen;
    logic [31:0] got_rdata;
    logic        got_err;
    issue(v, ok);
    if (!ok) return;
    if (v.hold == 0) bif.resp_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bif.resp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      check("resp_timeout", 32'h1, 32'h0);
      bif.resp_ready = 1'b0;
      return;
    end
    got_rdata = bif.resp_rdata;
    got_err   = bif.resp_err;
    if (v.hold > 0) begin
      repeat (v.hold) @(posedge clk);
      #1 bif.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bif.resp_ready = 1'b0;
    check("lit_rdata", got_rdata, v.exp_rdata);
    check("lit_err",   32'(got_err), 32'(v.exp_err));
  endtask

  task automatic reset_mid_txn();
    vec_t v;
    bit   ok;
    bit   hit;
`ifdef SUBWORD_RMW_EN
    v = mk(1'b1, 2'd0, 1'b0, 32'h0040_0001, 32'h0000_00AB, 32'h1122_3344, 32'h0, 1'b0, 0);
`else
    v = mk(1'b0, 2'd0, 1'b0, 32'h0040_0003, 32'h0, 32'h80FF_FFFF, 32'h0, 1'b0, 0);
`endif
    issue(v, ok);
    if (!ok) return;
    hit = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (dbg_state == RWAIT) begin hit = 1'b1; break; end
    end
    check("reach_rwait", 32'(hit), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_ready", 32'(bif.req_ready), 32'h0);
    check("abort_wr",    32'(bif.bus_wr), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("post_rst_ready", 32'(bif.req_ready), 32'h1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bif.req_valid    = 1'b0;
    bif.req_we       = 1'b0;
    bif.req_size     = 2'd0;
    bif.req_unsigned = 1'b0;
    bif.req_addr     = 32'h0;
    bif.req_wdata    = 32'h0;
    bif.resp_ready   = 1'b0;
    bif.bus_rdata    = 32'h0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Pin the model against hand-computed values.
    check("pin_lb",  model_load(2'd0, 1'b0, 32'h0040_0003, 32'h80FF_FFFF), 32'hFFFF_FF80);
    check("pin_lhu", model_load(2'd1, 1'b1, 32'h0040_0002, 32'h8001_0000), 32'h0000_8001);
    check("pin_mis", 32'(model_err(2'd2, 32'h0040_0002)), 32'h1);
`ifdef SUBWORD_RMW_EN
    check("pin_sb",  model_store(2'd0, 32'h0040_0001, 32'h0000_00AB, 32'h1122_3344), 32'h1122_AB44);
`else
    check("pin_sb",  model_store(2'd0, 32'h0040_0001, 32'h0000_00AB, 32'h1122_3344), 32'hABAB_ABAB);
`endif

    //               we    size  uns   addr           wdata          periph         exp_rdata      err   hold
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0040_0003, 32'h0,        32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0, 1));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h0040_0002, 32'h0,        32'h8001_0000, 32'h0000_8001, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0040_0002, 32'h0,        32'h8001_0000, 32'hFFFF_8001, 1'b0, 2));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h0040_0001, 32'h0,        32'h1122_3344, 32'h0000_0033, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0040_0000, 32'h0,        32'h1122_33F0, 32'hFFFF_FFF0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0040_0000, 32'h0,        32'h1122_8000, 32'hFFFF_8000, 1'b0, 5));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0040_0001, 32'h0,        32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0040_0001, 32'h0000_00AB, 32'h1122_3344, 32'h0,        1'b0, 0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h0040_0002, 32'h0000_BEEF, 32'h1122_3344, 32'h0,        1'b0, 1));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0040_0004, 32'hCAFE_F00D, 32'h0,         32'h0,        1'b0, 0));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0040_0002, 32'h1234_5678, 32'h0,         32'h0,        1'b1, 0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b1, 32'h0040_0003, 32'h0,        32'h0,         32'h0,        1'b1, 3));
    vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h0040_0008, 32'h0,        32'h8765_4321, 32'h8765_4321, 1'b0, 0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0040_0003, 32'hFFFF_FF5A, 32'hAABB_CCDD, 32'h0,        1'b0, 0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h0040_0002, 32'h0,        32'h00FE_0000, 32'h0000_00FE, 1'b0, 0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0040_0002, 32'h0,        32'h00FE_0000, 32'hFFFF_FFFE, 1'b0, 0));
    vecs.push_back(mk(1'b1, 2'd3, 1'b0, 32'h0040_0010, 32'hA5A5_0F0F, 32'h0,         32'h0,        1'b0, 0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h0040_0003, 32'h0000_1234, 32'h0,         32'h0,        1'b1, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    reset_mid_txn();

    run_vec(mk(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
